// File: rtl/display_sel_ctrl.sv
// Display group selector: debounced mode button toggles between the time group
// and a blinking alternate group that times out back to the time group.
module display_sel_ctrl #(
   parameter int TICK_DIV       = 100000,
   parameter int DEBOUNCE_TICKS = 20,
   parameter int HOLD_TICKS     = 5000,
   parameter int BLINK_TICKS    = 500
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_raw,
   input  logic lock,
   output logic selector,
   output logic blank,
   output logic sel_changed,
   output logic state
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam int BW = $clog2(BLINK_TICKS + 1);

   typedef enum logic {
      SHOW0 = 1'b0,
      SHOW1 = 1'b1
   } state_t;

   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick_s;
   logic          sync1_q, sync2_q;
   logic          deb_q, deb_d, deb_prev_q;
   logic [DW-1:0] stab_q, stab_d;
   logic          press_s;
   state_t        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [BW-1:0] blink_q, blink_d;
   logic          blank_q, blank_d;
   logic          sel_changed_q, sel_changed_d;

   // Free-running tick divider
   always_comb begin
      tick_s = (tick_cnt_q == TW'(TICK_DIV - 1));
      if (tick_s) begin
         tick_cnt_d = {TW{1'b0}};
      end else begin
         tick_cnt_d = tick_cnt_q + TW'(1);
      end
   end

   // Stability counter restarts whenever the input agrees with the accepted level
   always_comb begin
      deb_d  = deb_q;
      stab_d = stab_q;
      if (sync2_q == deb_q) begin
         stab_d = {DW{1'b0}};
      end else if (stab_q == DW'(DEBOUNCE_TICKS)) begin
         deb_d  = sync2_q;
         stab_d = {DW{1'b0}};
      end else if (tick_s) begin
         stab_d = stab_q + DW'(1);
      end else begin
         stab_d = stab_q;
      end
   end

   assign press_s = deb_q & ~deb_prev_q;

   // Group FSM; every exit from SHOW1 clears blank together with the selector
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      blink_d = blink_q;
      blank_d = blank_q;
      case (state_q)
         SHOW0: begin
            blank_d = 1'b0;
            hold_d  = {HW{1'b0}};
            blink_d = {BW{1'b0}};
            if (press_s && !lock) begin
               state_d = SHOW1;
               hold_d  = HW'(HOLD_TICKS);
               blink_d = BW'(BLINK_TICKS);
            end else begin
               state_d = SHOW0;
            end
         end
         SHOW1: begin
            if (lock || press_s) begin
               state_d = SHOW0;
               blank_d = 1'b0;
               hold_d  = {HW{1'b0}};
               blink_d = {BW{1'b0}};
            end else if (tick_s) begin
               if (hold_q == HW'(1)) begin
                  state_d = SHOW0;
                  blank_d = 1'b0;
                  hold_d  = {HW{1'b0}};
                  blink_d = {BW{1'b0}};
               end else begin
                  hold_d = hold_q - HW'(1);
                  if (blink_q == BW'(1)) begin
                     blank_d = ~blank_q;
                     blink_d = BW'(BLINK_TICKS);
                  end else begin
                     blink_d = blink_q - BW'(1);
                  end
               end
            end else begin
               state_d = SHOW1;
            end
         end
         default: begin
            state_d = SHOW0;
            blank_d = 1'b0;
            hold_d  = {HW{1'b0}};
            blink_d = {BW{1'b0}};
         end
      endcase
      sel_changed_d = (state_d != state_q);
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tick_cnt_q    <= {TW{1'b0}};
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         deb_q         <= 1'b0;
         deb_prev_q    <= 1'b0;
         stab_q        <= {DW{1'b0}};
         state_q       <= SHOW0;
         hold_q        <= {HW{1'b0}};
         blink_q       <= {BW{1'b0}};
         blank_q       <= 1'b0;
         sel_changed_q <= 1'b0;
      end else begin
         tick_cnt_q    <= tick_cnt_d;
         sync1_q       <= btn_raw;
         sync2_q       <= sync1_q;
         deb_q         <= deb_d;
         deb_prev_q    <= deb_q;
         stab_q        <= stab_d;
         state_q       <= state_d;
         hold_q        <= hold_d;
         blink_q       <= blink_d;
         blank_q       <= blank_d;
         sel_changed_q <= sel_changed_d;
      end
   end

   assign selector    = (state_q == SHOW1);
   assign state       = state_q;
   assign blank       = blank_q;
   assign sel_changed = sel_changed_q;

endmodule

// File: tb/tb_display_sel_ctrl.sv
// Scoreboard bench: stimulus queues expected selector transitions, a monitor
// checks each sel_changed pulse, dwell time and blink period.
module tb_display_sel_ctrl;

   logic clk = 1'b0;
   logic reset_n, btn_raw, lock;
   logic selector, blank, sel_changed, state;

   display_sel_ctrl #(
      .TICK_DIV(4), .DEBOUNCE_TICKS(3), .HOLD_TICKS(10), .BLINK_TICKS(2)
   ) dut (
      .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw), .lock(lock),
      .selector(selector), .blank(blank), .sel_changed(sel_changed), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic sel;
      int   lo;
      int   hi;
      int   dmin;
      int   dmax;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   logic rst_edge = 1'b1;
   logic prev_sel = 1'b0;
   logic prev_blank = 1'b0;
   int   last_chg = 0;
   int   entry = 0;
   int   last_tog = 0;
   bit   first_tog = 1'b1;
   int   d;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_edge <= !reset_n;
   end

   // Monitor: pops the scoreboard on each selector-change pulse
   always @(negedge clk) begin
      if (sel_changed) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse cyc=%0d selector=%0b required no pulse", cyc, selector);
         end else begin
            e = q.pop_front();
            if (selector !== e.sel || state !== e.sel || cyc < e.lo || cyc > e.hi ||
                (!selector && blank !== 1'b0)) begin
               errors++;
               $display("FAIL transition cyc=%0d sel=%0b state=%0b blank=%0b required sel=%0b state=%0b blank=0 in cyc %0d..%0d",
                        cyc, selector, state, blank, e.sel, e.sel, e.lo, e.hi);
            end
            if (e.dmax != 0) begin
               checks++;
               d = cyc - last_chg;
               if (d < e.dmin || d > e.dmax) begin
                  errors++;
                  $display("FAIL dwell got=%0d required %0d..%0d", d, e.dmin, e.dmax);
               end
            end
         end
         last_chg = cyc;
         if (selector) begin
            entry     = cyc;
            first_tog = 1'b1;
         end
      end
      if (!rst_edge && selector != prev_sel && !sel_changed) begin
         checks++;
         errors++;
         $display("FAIL missing_pulse cyc=%0d selector=%0b sel_changed=0 required 1", cyc, selector);
      end
      if (selector && !sel_changed && blank !== prev_blank) begin
         checks++;
         if (first_tog) begin
            d = cyc - entry;
            if (d < 5 || d > 8) begin
               errors++;
               $display("FAIL blink_first got=%0d required 5..8", d);
            end
         end else begin
            d = cyc - last_tog;
            if (d != 8) begin
               errors++;
               $display("FAIL blink_period got=%0d required 8", d);
            end
         end
         first_tog = 1'b0;
         last_tog  = cyc;
      end
      prev_sel   = selector;
      prev_blank = blank;
   end

   task automatic chk(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got=%0b required=%0b", name, act, req);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic sel, input int lo, input int hi, input int dmin, input int dmax);
      exp_t x;
      x.sel = sel; x.lo = lo; x.hi = hi; x.dmin = dmin; x.dmax = dmax;
      q.push_back(x);
   endtask

   task automatic press(input int hold, input bit rise, input bit fall);
      int k;
      btn_raw = 1'b1;
      k = cyc;
      if (rise) push(1'b1, k + 10, k + 18, 0, 0);
      if (fall) push(1'b0, k + 45, k + 60, 37, 40);
      step(hold);
      btn_raw = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         step(1);
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required 0 within %0d cycles", q.size(), budget);
         q.delete();
      end
   endtask

   initial begin
      int k;
      reset_n = 1'b0;
      btn_raw = 1'b0;
      lock    = 1'b0;
      step(3);
      chk("rst_selector", selector, 1'b0);
      chk("rst_blank", blank, 1'b0);
      chk("rst_state", state, 1'b0);
      chk("rst_sel_changed", sel_changed, 1'b0);
      reset_n = 1'b1;

      step(200);
      chk("idle_selector", selector, 1'b0);
      chk("idle_blank", blank, 1'b0);

      // held press: enter, blink, time out after release
      press(40, 1'b1, 1'b1);
      wait_drain(100);
      step(30);
      chk("hold_end_selector", selector, 1'b0);

      // short press then no input
      press(20, 1'b1, 1'b1);
      wait_drain(100);
      step(20);
      chk("short_end_blank", blank, 1'b0);

      // glitches 1..8 cycles with 3-cycle gaps
      for (int len = 1; len <= 8; len++) begin
         btn_raw = 1'b1;
         step(len);
         btn_raw = 1'b0;
         step(3);
      end
      step(20);
      chk("glitch_selector", selector, 1'b0);

      // lock pulse in SHOW1, locked press ignored, later press accepted
      press(20, 1'b1, 1'b0);
      wait_drain(10);
      lock = 1'b1;
      k = cyc;
      push(1'b0, k + 1, k + 1, 0, 0);
      step(1);
      lock = 1'b0;
      wait_drain(10);
      lock = 1'b1;
      press(20, 1'b0, 1'b0);
      step(20);
      chk("locked_selector", selector, 1'b0);
      lock = 1'b0;
      press(20, 1'b1, 1'b1);
      wait_drain(100);
      step(20);

      // reset pulse mid-SHOW1
      press(20, 1'b1, 1'b0);
      wait_drain(10);
      step(5);
      reset_n = 1'b0;
      step(1);
      reset_n = 1'b1;
      chk("midrst_selector", selector, 1'b0);
      chk("midrst_blank", blank, 1'b0);
      chk("midrst_state", state, 1'b0);
      chk("midrst_sel_changed", sel_changed, 1'b0);
      step(80);
      chk("midrst_idle_selector", selector, 1'b0);

      // button held through reset release yields one press
      btn_raw = 1'b1;
      reset_n = 1'b0;
      step(2);
      reset_n = 1'b1;
      k = cyc;
      push(1'b1, k + 10, k + 18, 0, 0);
      push(1'b0, k + 45, k + 62, 37, 40);
      wait_drain(120);
      step(20);
      btn_raw = 1'b0;
      step(30);
      chk("final_selector", selector, 1'b0);
      wait_drain(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
